// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU: default datapath geometry and the
// opcode set decoded by the control FSM.
package cpu_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NREG   = 4;
  localparam int DEF_RSEL_W = 2;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOADI = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_ADDI  = 4'h4,
    OP_ADD   = 4'h5,
    OP_SUBI  = 4'h6,
    OP_SUB   = 4'h7,
    OP_XORI  = 4'h8,
    OP_XOR   = 4'h9
  } opcode_t;

  // Source-select decode shared by the FSM and the datapath: 1 selects imm.
  function automatic logic op_uses_imm(input opcode_t op);
    logic sel;
    case (op)
      OP_LOADI, OP_ADDI, OP_SUBI, OP_XORI: sel = 1'b1;
      default:                             sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bitserial_shifter.sv
// Operand snapshot register: parallel load, LSB-first right shift and a bit
// counter that flags when the last bit is on the output.
module bitserial_shifter
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit0,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] sh_r;
  logic [CNT_W-1:0] cnt_r;

  // Load has priority; a load with shift already consumes bit 0 via the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r  <= '0;
      cnt_r <= '0;
    end else if (load) begin
      if (shift) begin
        sh_r  <= {1'b0, din[WIDTH-1:1]};
        cnt_r <= CNT_W'(1);
      end else begin
        sh_r  <= din;
        cnt_r <= '0;
      end
    end else if (shift) begin
      sh_r  <= {1'b0, sh_r[WIDTH-1:1]};
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      sh_r  <= sh_r;
      cnt_r <= cnt_r;
    end
  end

  assign bit0 = sh_r[0];
  assign last = (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bitserial_datapath.sv
// Bit-serial CPU datapath: accumulator, register file, operand streaming to the
// serial ALU and result collection back into the accumulator.
module bitserial_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREG   = DEF_NREG,
  parameter int RSEL_W = DEF_RSEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_start,
  input  logic              reg_shift_en,
  input  logic              acc_write_en,
  input  logic              acc_load_en,
  input  logic              reg_store_en,
  input  logic [RSEL_W-1:0] reg_sel,
  input  logic [WIDTH-1:0]  imm,
  input  logic              imm_sel,
  input  logic              alu_res_bit,
  output logic              alu_a_bit,
  output logic              alu_b_bit,
  output logic              bit_done,
  output logic [WIDTH-1:0]  acc_value,
  output logic              busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] regs_r [NREG];
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] src_s;
  logic [CNT_W-1:0] wr_cnt_r;
  logic             rd_act_r;
  logic             wr_act_r;
  logic             shift_s;
  logic             a_sh0_s;
  logic             b_sh0_s;
  logic             a_last_s;
  logic             b_last_s;

  assign src_s   = imm_sel ? imm : regs_r[reg_sel];
  assign shift_s = reg_shift_en & (alu_start | rd_act_r);

  bitserial_shifter #(.WIDTH(WIDTH)) u_a_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (alu_start),
    .shift (shift_s),
    .din   (acc_r),
    .bit0  (a_sh0_s),
    .last  (a_last_s)
  );

  bitserial_shifter #(.WIDTH(WIDTH)) u_b_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (alu_start),
    .shift (shift_s),
    .din   (src_s),
    .bit0  (b_sh0_s),
    .last  (b_last_s)
  );

  // Bit 0 bypasses the snapshot in the start cycle; idle outputs are held at 0.
  always_comb begin
    alu_a_bit = 1'b0;
    alu_b_bit = 1'b0;
    if (alu_start) begin
      alu_a_bit = acc_r[0];
      alu_b_bit = src_s[0];
    end else begin
      alu_a_bit = rd_act_r & a_sh0_s;
      alu_b_bit = rd_act_r & b_sh0_s;
    end
  end

  assign bit_done  = reg_shift_en & rd_act_r & a_last_s & b_last_s;
  assign busy      = rd_act_r | wr_act_r;
  assign acc_value = acc_r;

  // Read/write phase tracking; a parallel load cancels any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_act_r <= 1'b0;
      wr_act_r <= 1'b0;
      wr_cnt_r <= '0;
    end else if (acc_load_en) begin
      rd_act_r <= 1'b0;
      wr_act_r <= 1'b0;
      wr_cnt_r <= wr_cnt_r;
    end else if (alu_start) begin
      rd_act_r <= 1'b1;
      wr_act_r <= 1'b1;
      wr_cnt_r <= '0;
    end else begin
      if (reg_shift_en && rd_act_r && a_last_s) begin
        rd_act_r <= 1'b0;
      end else begin
        rd_act_r <= rd_act_r;
      end
      if (acc_write_en && wr_act_r) begin
        wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        if (wr_cnt_r == CNT_W'(WIDTH - 1)) begin
          wr_act_r <= 1'b0;
        end else begin
          wr_act_r <= 1'b1;
        end
      end else begin
        wr_cnt_r <= wr_cnt_r;
        wr_act_r <= wr_act_r;
      end
    end
  end

  // Accumulator: parallel load, else result bits enter at the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (acc_load_en) begin
      acc_r <= src_s;
    end else if (acc_write_en && wr_act_r && !alu_start) begin
      acc_r <= {alu_res_bit, acc_r[WIDTH-1:1]};
    end else begin
      acc_r <= acc_r;
    end
  end

  // Register file store always takes the pre-edge accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (reg_store_en) begin
      regs_r[reg_sel] <= acc_r;
    end else begin
      regs_r <= regs_r;
    end
  end

endmodule

// File: tb/tb_bitserial_datapath.sv
// Randomized self-checking bench for bitserial_datapath against an
// arithmetic reference model of the accumulator and register file.
module tb_bitserial_datapath;

  localparam int W = 8;
  localparam int M_PASS = 0;
  localparam int M_ADD  = 1;
  localparam int M_XOR  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_start, reg_shift_en, acc_write_en, acc_load_en, reg_store_en;
  logic [1:0]   reg_sel;
  logic [W-1:0] imm;
  logic         imm_sel, alu_res_bit;
  logic         alu_a_bit, alu_b_bit, bit_done, busy;
  logic [W-1:0] acc_value;

  logic [W-1:0] acc_m;
  logic [W-1:0] regs_m [4];
  int           n_checks = 0;
  int           n_fail = 0;

  bitserial_datapath #(.WIDTH(W), .NREG(4), .RSEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .alu_start(alu_start), .reg_shift_en(reg_shift_en),
    .acc_write_en(acc_write_en), .acc_load_en(acc_load_en), .reg_store_en(reg_store_en),
    .reg_sel(reg_sel), .imm(imm), .imm_sel(imm_sel), .alu_res_bit(alu_res_bit),
    .alu_a_bit(alu_a_bit), .alu_b_bit(alu_b_bit), .bit_done(bit_done),
    .acc_value(acc_value), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_start = 1'b0; reg_shift_en = 1'b0; acc_write_en = 1'b0;
    acc_load_en = 1'b0; reg_store_en = 1'b0; alu_res_bit = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic alu_bit(input int mode, input logic a, input logic b, input logic c);
    if (mode == M_ADD) return a ^ b ^ c;
    else if (mode == M_XOR) return a ^ b;
    else return a;
  endfunction

  task automatic load_imm(input logic [W-1:0] v);
    idle_inputs(); imm = v; imm_sel = 1'b1; acc_load_en = 1'b1;
    next_cycle(); idle_inputs(); acc_m = v;
    check_eq("load_imm", acc_value, acc_m);
  endtask

  task automatic load_reg(input int r);
    idle_inputs(); reg_sel = r[1:0]; imm_sel = 1'b0; acc_load_en = 1'b1;
    next_cycle(); idle_inputs(); acc_m = regs_m[r];
    check_eq("load_reg", acc_value, acc_m);
  endtask

  task automatic store_reg(input int r);
    idle_inputs(); reg_sel = r[1:0]; reg_store_en = 1'b1;
    next_cycle(); idle_inputs(); regs_m[r] = acc_m;
  endtask

  // Runs the first n cycles of an op; accepted writes update the model.
  task automatic partial_op(input int mode, input logic isel, input int r,
                            input logic [W-1:0] iv, input int n);
    logic c, pend;
    c = 1'b0; pend = 1'b0;
    imm = iv; imm_sel = isel; reg_sel = r[1:0];
    for (int k = 0; k < n; k++) begin
      alu_start = (k == 0); reg_shift_en = 1'b1; acc_write_en = (k > 0);
      alu_res_bit = pend;
      #1;
      if (k > 0) acc_m = {pend, acc_m[W-1:1]};
      pend = alu_bit(mode, alu_a_bit, alu_b_bit, c);
      c = (alu_a_bit & alu_b_bit) | (c & (alu_a_bit ^ alu_b_bit));
      next_cycle();
    end
    idle_inputs();
  endtask

  // Full serial op; load_k > 0 issues a parallel load of lv in write cycle load_k.
  task automatic run_op(input int mode, input logic isel, input int r, input logic [W-1:0] iv,
                        input int load_k, input logic [W-1:0] lv);
    logic [W-1:0] a, b, exp;
    logic c, pend;
    a = acc_m;
    b = isel ? iv : regs_m[r];
    if (mode == M_ADD) exp = a + b;
    else if (mode == M_XOR) exp = a ^ b;
    else exp = a;
    if (load_k > 0) exp = lv;
    c = 1'b0; pend = 1'b0;
    imm = iv; imm_sel = isel; reg_sel = r[1:0];
    for (int k = 0; k <= W; k++) begin
      alu_start = (k == 0); reg_shift_en = (k < W); acc_write_en = (k > 0);
      alu_res_bit = pend;
      acc_load_en = (load_k > 0 && k == load_k);
      if (acc_load_en) begin
        imm = lv; imm_sel = 1'b1;
      end
      #1;
      if (k < W) begin
        if (load_k == 0 || k <= load_k) begin
          check_eq("a_bit", alu_a_bit, a[k]);
          check_eq("b_bit", alu_b_bit, b[k]);
          check_eq("bit_done", bit_done, (k == W - 1));
        end else begin
          check_eq("done_after_load", bit_done, 1'b0);
          check_eq("a_after_load", alu_a_bit, 1'b0);
        end
        pend = alu_bit(mode, alu_a_bit, alu_b_bit, c);
        c = (alu_a_bit & alu_b_bit) | (c & (alu_a_bit ^ alu_b_bit));
      end else if (load_k == 0) begin
        check_eq("busy_last_write", busy, 1'b1);
      end
      next_cycle();
      acc_load_en = 1'b0;
    end
    idle_inputs();
    #1;
    check_eq("busy_end", busy, 1'b0);
    check_eq("acc_result", acc_value, exp);
    acc_m = exp;
  endtask

  task automatic extra_strobes();
    for (int k = 0; k < 3; k++) begin
      reg_shift_en = 1'b1; acc_write_en = 1'b1; alu_res_bit = 1'($urandom_range(0, 1));
      #1;
      check_eq("extra_done", bit_done, 1'b0);
      check_eq("extra_a_bit", alu_a_bit, 1'b0);
      next_cycle();
    end
    idle_inputs();
    check_eq("extra_acc", acc_value, acc_m);
  endtask

  initial begin
    idle_inputs();
    reg_sel = 2'd0; imm = '0; imm_sel = 1'b0;
    rst_n = 1'b0;
    acc_m = '0;
    for (int i = 0; i < 4; i++) regs_m[i] = '0;
    #1;
    check_eq("rst_acc", acc_value, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_a_bit", alu_a_bit, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // Reset in the middle of an ADD clears everything asynchronously.
    for (int i = 0; i < 4; i++) begin
      load_imm(8'(8'h11 * (i + 1)));
      store_reg(i);
    end
    partial_op(M_ADD, 1'b0, 1, 8'h00, 2);
    reg_shift_en = 1'b1; acc_write_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midop_rst_acc", acc_value, 8'h00);
    check_eq("midop_rst_busy", busy, 1'b0);
    check_eq("midop_rst_done", bit_done, 1'b0);
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    acc_m = '0;
    for (int i = 0; i < 4; i++) regs_m[i] = '0;
    for (int i = 0; i < 4; i++) load_reg(i);

    // Pass-through of a loaded immediate.
    load_imm(8'hA5);
    run_op(M_PASS, 1'b1, 0, 8'h00, 0, 8'h00);

    // Serial add from a register.
    load_imm(8'h0F);
    store_reg(2);
    load_imm(8'h3C);
    run_op(M_ADD, 1'b0, 2, 8'h00, 0, 8'h00);

    // Store/load round trip.
    load_imm(8'h77);
    store_reg(3);
    load_imm(8'h00);
    load_reg(3);

    extra_strobes();

    // Restart at the fourth shift, then a load during the write phase.
    load_imm(8'h5A);
    partial_op(M_ADD, 1'b1, 0, 8'h23, 3);
    run_op(M_ADD, 1'b1, 0, 8'h19, 0, 8'h00);
    run_op(M_XOR, 1'b1, 0, 8'hC3, 4, 8'h6E);
    extra_strobes();

    // Randomized mix of loads, stores and serial ops.
    for (int it = 0; it < 60; it++) begin
      int op, r;
      logic [W-1:0] v;
      op = $urandom_range(0, 5);
      r  = $urandom_range(0, 3);
      v  = 8'($urandom_range(0, 255));
      case (op)
        0: load_imm(v);
        1: load_reg(r);
        2: store_reg(r);
        3: run_op(M_ADD, 1'($urandom_range(0, 1)), r, v, 0, 8'h00);
        4: run_op(M_XOR, 1'($urandom_range(0, 1)), r, v, 0, 8'h00);
        default: run_op(M_PASS, 1'($urandom_range(0, 1)), r, v, 0, 8'h00);
      endcase
    end
    for (int i = 0; i < 4; i++) load_reg(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitserial_datapath.md
Name: bitserial_datapath

Overview:
- Responder end of the control interface driven by the bit-serial CPU control FSM.
- Holds the accumulator and a small register file.
- On the FSM's shift strobes, streams operand bits LSB-first to the serial ALU and shifts ALU result bits back into the accumulator.
- Generates bit_done for the FSM and executes the single-cycle load and store actions.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- NREG, 4, number of general registers (power of two).
- RSEL_W, 2, register-select width, equal to log2(NREG).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_start  in  1  start of serial op; capture operands
- reg_shift_en  in  1  present next operand bit pair this cycle
- acc_write_en  in  1  accept one ALU result bit this cycle
- acc_load_en  in  1  parallel-load accumulator
- reg_store_en  in  1  store accumulator to reg[reg_sel]
- reg_sel  in  RSEL_W  register index for operand, load and store
- imm  in  WIDTH  immediate operand
- imm_sel  in  1  1: B operand/load source is imm; 0: reg[reg_sel]
- alu_res_bit  in  1  serial ALU result bit (registered in ALU, one cycle after its operand bits)
- alu_a_bit  out  1  current A bit (accumulator snapshot)
- alu_b_bit  out  1  current B bit (operand snapshot)
- bit_done  out  1  last operand bit being presented this cycle
- acc_value  out  WIDTH  accumulator contents
- busy  out  1  serial operation in progress

Behaviour:
- Reset (async, rst_n=0):
  - acc, all registers, a_sh, b_sh, rd_cnt, wr_cnt, rd_act and wr_act clear to 0.
  - All outputs therefore reset to 0.
- alu_start (sampled at posedge):
  - a_sh <= acc.
  - b_sh <= imm_sel ? imm : reg[reg_sel].
  - rd_cnt <= 0, wr_cnt <= 0, rd_act <= 1, wr_act <= 1.
  - Asserting alu_start while busy aborts the current op and restarts it.
- Operand bits during the start cycle itself: alu_a_bit = acc[0] and alu_b_bit = selected source bit 0, both combinational bypass.
  - Rationale: the FSM asserts alu_start and reg_shift_en together, and bit 0 must be valid in that same cycle.
- Read phase, on each reg_shift_en while rd_act (or with alu_start):
  - Present bit rd_cnt.
  - a_sh and b_sh shift right by one.
  - rd_cnt increments.
- Outside the start cycle, alu_a_bit = a_sh[0] and alu_b_bit = b_sh[0].
- bit_done = reg_shift_en & rd_act & (rd_cnt == WIDTH-1).
  - Combinational from registered state, so the FSM sees it in the cycle the MSB is presented.
  - On that edge rd_act <= 0.
- reg_shift_en with rd_act=0 and no alu_start:
  - Ignored; bit_done stays 0.
  - Operand outputs hold 0.
- Write phase, on each acc_write_en while wr_act:
  - acc <= {alu_res_bit, acc[WIDTH-1:1]}; wr_cnt increments.
  - After WIDTH writes, wr_act <= 0 and acc holds the full result in normal bit order.
  - acc_write_en with wr_act=0 is ignored.
- Latency for a WIDTH=8 op:
  - 8 shift cycles (start cycle plus 7) and 8 write cycles, the writes lagging the reads by one cycle.
  - acc_value is final on the edge after the last write cycle.
- busy = rd_act | wr_act.
- acc_load_en:
  - acc <= imm_sel ? imm : reg[reg_sel].
  - Clears rd_act and wr_act (load wins over any in-flight write).
- reg_store_en:
  - reg[reg_sel] <= acc, using the pre-edge acc value.
  - If it coincides with acc_write_en, the store uses the old acc and the write proceeds.
- acc_load_en with reg_store_en in the same cycle: the store takes the old acc and the load takes effect.
- Width rules: counters are clog2(WIDTH)+1 bits wide; no wrap occurs because the active flags stop the counting.

Decomposition:
- Shared package (cpu_pkg) holds WIDTH, NREG and RSEL_W defaults, plus the opcode constants already used by the control FSM, so source-select decoding stays consistent.
- One natural sub-module: bitserial_shifter.
  - Parallel load, right shift, bit-0 output and an internal counter with a last-bit flag.
  - Instantiated twice, for A and for B.
- The register file stays inline.

Test Plan:
- Reset mid-op: start an ADD, assert rst_n=0 at the third shift -> acc=0, busy=0, bit_done=0 immediately (async), all registers 0.
- LOADI then serial pass-through:
  - Stimulus: imm=8'hA5, imm_sel=1, acc_load_en; then alu_start+shift, 7 shifts, 1 write-only cycle, feeding alu_res_bit=alu_a_bit delayed one cycle.
  - Response: alu_a_bit sequence 1,0,1,0,0,1,0,1; bit_done high only on the 8th shift cycle; acc=8'hA5 after.
- ADD via external model:
  - Stimulus: acc=8'h3C, reg[2]=8'h0F, imm_sel=0, reg_sel=2, serial adder model on the bit outputs.
  - Response: acc=8'h4B, busy falls one cycle after the last write.
- Store/load round-trip: acc=8'h77, reg_store_en with reg_sel=3; then acc_load_en with imm_sel=0, reg_sel=3 after loading acc=0 -> reg[3]=8'h77, acc=8'h77.
- Extra strobes: 3 reg_shift_en and acc_write_en pulses after an op completes -> acc unchanged, bit_done stays 0.
- Abort/restart and load-override:
  - alu_start at the 4th shift -> a_sh recaptured and bit_done on the 8th shift after the restart.
  - acc_load_en during the write phase -> acc=load value, remaining writes ignored.
